kernel_map_binop_pipe: RTL

// - Parametrised successor of the TyTra leaf map node: LANES-wide vector of two-operand stream ops.
// - Configurable op (OP) and pipeline depth (LAT); all LANES share one stall-correct valid/ready pipeline.
// - Sits between upstream stream sources and downstream map/reduce nodes in generated kernels.

---
 rtl/kernel_map_binop_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/kernel_map_binop_pipe.sv
// LANES-wide two-operand stream map node: per-lane OP over a LAT-stage stall-correct pipeline.
// Build option KERNEL_MAP_BINOP_SKID_EN adds a 2-entry output skid buffer and a registered iready.
module kernel_map_binop_pipe #(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned LANES   = 4,
  parameter int unsigned LAT     = 2,
  parameter int unsigned OP      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ivalid_in1_s0,
  input  logic                     ivalid_in2_s0,
  output logic                     iready,
  input  logic [LANES*STREAMW-1:0] in1_s0,
  input  logic [LANES*STREAMW-1:0] in2_s0,
  output logic                     ovalid,
  input  logic                     oready,
  output logic [LANES*STREAMW-1:0] out1_s0,
  output logic [31:0]              obeat_count
);

  localparam int unsigned VW = LANES * STREAMW;
  typedef logic [VW-1:0] vec_t;

  if (LAT < 1) begin : g_bad_lat
    $error("kernel_map_binop_pipe: LAT must be at least 1");
  end
  if (OP > 5) begin : g_bad_op
    $error("kernel_map_binop_pipe: OP must be in 0..5");
  end

  // Lanes are independent: each result is truncated to STREAMW bits, no carry crosses lanes.
  function automatic vec_t lane_op(input vec_t a, input vec_t b);
    vec_t r;
    r = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      logic [STREAMW-1:0] x;
      logic [STREAMW-1:0] y;
      x = a[i*STREAMW +: STREAMW];
      y = b[i*STREAMW +: STREAMW];
      case (OP)
        0:       r[i*STREAMW +: STREAMW] = x + y;
        1:       r[i*STREAMW +: STREAMW] = x - y;
        2:       r[i*STREAMW +: STREAMW] = x * y;
        3:       r[i*STREAMW +: STREAMW] = x & y;
        4:       r[i*STREAMW +: STREAMW] = x | y;
        default: r[i*STREAMW +: STREAMW] = x ^ y;
      endcase
    end
    return r;
  endfunction

  logic [LAT-1:0] v_q;
  logic [LAT-1:0] v_d;
  logic [LAT-1:0] v_in;
  logic [LAT-1:0] move;
  logic [LAT:0]   rdy;
  vec_t           data_q [LAT];
  vec_t           d_in   [LAT];
  logic           last_ready;
  logic           in_fire;
  logic [31:0]    obeat_count_q;

  assign in_fire = ivalid_in1_s0 & ivalid_in2_s0 & iready;

  // rdy[k] means stage k loads this edge; it ripples back from the output so bubbles collapse.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    move    = '0;
    rdy     = '0;
    v_in    = '0;
    v_d     = v_q;
    rdy[LAT] = last_ready;
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      move[k] = v_q[k] & rdy[k+1];
      rdy[k]  = ~v_q[k] | move[k];
    end
    v_in[0] = in_fire;
    d_in[0] = lane_op(in1_s0, in2_s0);
    for (int k = 1; k < int'(LAT); k++) begin
      v_in[k] = v_q[k-1];
      d_in[k] = data_q[k-1];
    end
    for (int k = 0; k < int'(LAT); k++) begin
      if (rdy[k]) v_d[k] = v_in[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so each stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      // NOTE: data registers are cleared as well, so out1_s0 reads 0 after reset, not stale lanes.
      for (int k = 0; k < int'(LAT); k++) data_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(LAT); k++) begin
        if (rdy[k] && v_in[k]) data_q[k] <= d_in[k];
      end
    end
  end

`ifdef KERNEL_MAP_BINOP_SKID_EN
  logic [1:0] sk_cnt_q;
  logic [1:0] sk_cnt_d;
  vec_t       sk_e0_q;
  vec_t       sk_e1_q;
  logic       iready_q;
  logic       iready_d;
  logic       push;
  logic       pop;

  // The skid only admits from the pipe while it has room, so iready never sees oready.
  assign last_ready = (sk_cnt_q != 2'd2);
  assign push       = move[LAT-1];
  assign ovalid     = (sk_cnt_q != 2'd0);
  assign pop        = ovalid & oready;
  assign out1_s0    = sk_e0_q;
  assign iready     = iready_q;

  always_comb begin
    sk_cnt_d = sk_cnt_q + {1'b0, push} - {1'b0, pop};
    iready_d = ~((sk_cnt_d == 2'd2) & (&v_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_cnt_q <= 2'd0;
      sk_e0_q  <= '0;
      sk_e1_q  <= '0;
      iready_q <= 1'b1;
    end else begin
      sk_cnt_q <= sk_cnt_d;
      iready_q <= iready_d;
      if (push && pop) begin
        sk_e0_q <= data_q[LAT-1];
      end else if (push) begin
        if (sk_cnt_q == 2'd0) sk_e0_q <= data_q[LAT-1];
        else                  sk_e1_q <= data_q[LAT-1];
      end else if (pop && sk_cnt_q == 2'd2) begin
        sk_e0_q <= sk_e1_q;
      end
    end
  end
`else
  assign last_ready = oready;
  assign ovalid     = v_q[LAT-1];
  assign out1_s0    = data_q[LAT-1];
  assign iready     = rdy[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obeat_count_q <= 32'd0;
    end else if (ovalid && oready) begin
      obeat_count_q <= obeat_count_q + 32'd1;
    end
  end

  assign obeat_count = obeat_count_q;

endmodule
